// File: rtl/cell_ram_pkg.sv
// Shared definitions for the cell RAM responder: FSM states, control-register
// select codes and the register reset/ID values.
package cell_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR,
        CR_RD
    } RamState;

    localparam logic [1:0] SEL_RCR  = 2'b00;
    localparam logic [1:0] SEL_DIDR = 2'b01;
    localparam logic [1:0] SEL_BCR  = 2'b10;

    localparam logic [15:0] BCR_DEFAULT  = 16'h9D1F;
    localparam logic [15:0] RCR_DEFAULT  = 16'h0010;
    localparam logic [15:0] DIDR_DEFAULT = 16'h0343;

    // Picks the control register addressed by a register-read select code;
    // the unassigned code reads back as zero.
    function automatic logic [15:0] selectReg(input logic [1:0]  sel,
                                              input logic [15:0] rcr,
                                              input logic [15:0] bcr,
                                              input logic [15:0] didr);
        case (sel)
            SEL_RCR:  return rcr;
            SEL_DIDR: return didr;
            SEL_BCR:  return bcr;
            default:  return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/cell_ram_array.sv
// Single-port synchronous word RAM with independent low/high byte write
// enables. Reads return the old contents on a same-cycle write.
module cell_ram_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  iClock,
    input  logic [DEPTH_LOG2-1:0] iAddr,
    input  logic [15:0]           iWrData,
    input  logic                  iWeLo,
    input  logic                  iWeHi,
    output logic [15:0]           oRdData
);

    logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // Byte-lane writes and a registered read of the same address every cycle.
    always_ff @(posedge iClock) begin
        if (iWeLo) begin
            mem[iAddr][7:0] <= iWrData[7:0];
        end
        if (iWeHi) begin
            mem[iAddr][15:8] <= iWrData[15:8];
        end
        oRdData <= mem[iAddr];
    end

endmodule

// File: rtl/cell_ram_responder.sv
// Synchronous CellularRAM-style bus responder: decodes accesses from the
// controller strobes, emulates the array and the BCR/RCR/DIDR registers, and
// drives the shared data bus with per-lane tri-state control.
module cell_ram_responder
    import cell_ram_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          READ_LAT   = 2,
    parameter logic [15:0] BCR_RST    = BCR_DEFAULT,
    parameter logic [15:0] RCR_RST    = RCR_DEFAULT,
    parameter logic [15:0] DIDR_VAL   = DIDR_DEFAULT
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iADV_n,
    input  logic        iCRE,
    input  logic        iCE_n,
    input  logic        iOE_n,
    input  logic        iWE_n,
    input  logic        iLB_n,
    input  logic        iUB_n,
    input  logic [22:0] iAddr,
    inout  wire  [15:0] dq,
    output logic        oWait
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

    RamState               state;
    logic [CNT_W-1:0]      waitCnt;
    logic [DEPTH_LOG2-1:0] addrReg;
    logic                  creReg;
    logic [15:0]           crData;
    logic [15:0]           capData;
    logic                  capLbN;
    logic                  capUbN;
    logic [15:0]           bcr;
    logic [15:0]           rcr;
    logic                  driveLo;
    logic                  driveHi;
    logic [15:0]           ramRdData;
    logic [15:0]           rdWord;
    logic                  start;
    logic                  commitWr;
    logic [1:0]            regSel;
    logic                  unusedAddrBits;

    // Access-start detection and the register selector carried on the address.
    assign start  = !iCE_n && !iADV_n;
    assign regSel = iAddr[19:18];

    // Address bits that neither the array nor the register path look at.
    assign unusedAddrBits = ^{iAddr[22:20], iAddr[17:16]};

    // A burst write lands the last captured word when it ends for any reason
    // other than reset: WE rising, CE rising, or a new access starting.
    assign commitWr = (state == WR) && !iReset && (iCE_n || iWE_n || start);

    // The array is addressed by the latched access address for both the
    // pending read and the write commit.
    cell_ram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) uArray (
        .iClock (iClock),
        .iAddr  (addrReg),
        .iWrData(capData),
        .iWeLo  (commitWr && !capLbN),
        .iWeHi  (commitWr && !capUbN),
        .oRdData(ramRdData)
    );

    // Read data source follows the kind of access that was started.
    assign rdWord = creReg ? crData : ramRdData;

    // Each byte lane is released whenever its registered enable is low.
    assign dq[7:0]  = driveLo ? rdWord[7:0]  : 8'hzz;
    assign dq[15:8] = driveHi ? rdWord[15:8] : 8'hzz;

    // Access FSM with registered wait and lane-drive outputs; CE high or a new
    // start overrides whatever is in progress.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state   <= IDLE;
            waitCnt <= '0;
            addrReg <= '0;
            creReg  <= 1'b0;
            crData  <= '0;
            capData <= '0;
            capLbN  <= 1'b0;
            capUbN  <= 1'b0;
            bcr     <= BCR_RST;
            rcr     <= RCR_RST;
            oWait   <= 1'b0;
            driveLo <= 1'b0;
            driveHi <= 1'b0;
        end else begin
            driveLo <= 1'b0;
            driveHi <= 1'b0;
            if (start) begin
                addrReg <= iAddr[DEPTH_LOG2-1:0];
                creReg  <= iCRE;
                waitCnt <= CNT_INIT;
                oWait   <= 1'b0;
                if (!iWE_n && !iCRE) begin
                    state   <= WR;
                    capData <= dq;
                    capLbN  <= iLB_n;
                    capUbN  <= iUB_n;
                end else if (!iWE_n) begin
                    state <= IDLE;
                    if (regSel == SEL_RCR) begin
                        rcr <= iAddr[15:0];
                    end else if (regSel == SEL_BCR) begin
                        bcr <= iAddr[15:0];
                    end
                end else if (!iOE_n) begin
                    state  <= iCRE ? CR_RD : RD_WAIT;
                    oWait  <= 1'b1;
                    crData <= selectReg(regSel, rcr, bcr, DIDR_VAL);
                end else begin
                    state <= IDLE;
                end
            end else if (iCE_n) begin
                state <= IDLE;
                oWait <= 1'b0;
            end else begin
                case (state)
                    WR: begin
                        if (iWE_n) begin
                            state <= IDLE;
                        end else begin
                            capData <= dq;
                            capLbN  <= iLB_n;
                            capUbN  <= iUB_n;
                        end
                    end
                    RD_WAIT, RD_DRIVE, CR_RD: begin
                        if (oWait && (waitCnt != '0)) begin
                            waitCnt <= waitCnt - 1'b1;
                        end else begin
                            oWait   <= 1'b0;
                            driveLo <= !iOE_n && !iLB_n;
                            driveHi <= !iOE_n && !iUB_n;
                            if (state == RD_WAIT) begin
                                state <= RD_DRIVE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cell_ram_responder.sv
// Directed bench for cell_ram_responder: register defaults, array write/read,
// byte lanes, aliasing, aborts and reset. Undriven bus lanes read as ones.
module tb_cell_ram_responder;

    localparam logic [15:0] HIZ = 16'hFFFF;

    logic        iClock;
    logic        iReset;
    logic        iADV_n;
    logic        iCRE;
    logic        iCE_n;
    logic        iOE_n;
    logic        iWE_n;
    logic        iLB_n;
    logic        iUB_n;
    logic [22:0] iAddr;
    wire  [15:0] dq;
    logic        oWait;
    logic        tbDrive;
    logic [15:0] tbDq;
    int          checkCount;
    int          errorCount;

    assign dq = tbDrive ? tbDq : 16'hzzzz;
    pullup (dq);

    cell_ram_responder #(
        .DEPTH_LOG2(10),
        .READ_LAT  (2)
    ) dut (
        .iClock(iClock),
        .iReset(iReset),
        .iADV_n(iADV_n),
        .iCRE  (iCRE),
        .iCE_n (iCE_n),
        .iOE_n (iOE_n),
        .iWE_n (iWE_n),
        .iLB_n (iLB_n),
        .iUB_n (iUB_n),
        .iAddr (iAddr),
        .dq    (dq),
        .oWait (oWait)
    );

    // Free-running clock.
    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic applyStimulus(input logic advN, input logic cre, input logic ceN,
                                 input logic oeN, input logic weN, input logic lbN,
                                 input logic ubN, input logic [22:0] addr,
                                 input logic drv, input logic [15:0] data);
        iADV_n  = advN;
        iCRE    = cre;
        iCE_n   = ceN;
        iOE_n   = oeN;
        iWE_n   = weN;
        iLB_n   = lbN;
        iUB_n   = ubN;
        iAddr   = addr;
        tbDrive = drv;
        tbDq    = data;
    endtask

    task automatic busIdle();
        applyStimulus(1, 0, 1, 1, 1, 1, 1, 23'h0, 0, 16'h0);
    endtask

    task automatic arrayWrite(input logic [22:0] addr, input logic [15:0] data,
                              input logic lbN, input logic ubN, input logic oeN);
        applyStimulus(0, 0, 0, oeN, 0, lbN, ubN, addr, 1, data);
        tick();
        checkOutput($sformatf("wr%0h/wait", addr), oWait, 0);
        applyStimulus(1, 0, 0, 1, 1, 1, 1, addr, 0, 16'h0);
        tick();
        busIdle();
        tick();
    endtask

    task automatic regWrite(input logic [1:0] sel, input logic [15:0] value);
        applyStimulus(0, 1, 0, 1, 0, 1, 1, {3'b000, sel, 2'b00, value}, 0, 16'h0);
        tick();
        busIdle();
        tick();
    endtask

    task automatic doRead(input string tag, input logic cre, input logic [22:0] addr,
                          input logic lbN, input logic ubN, input logic [15:0] expected);
        applyStimulus(0, cre, 0, 0, 1, lbN, ubN, addr, 0, 16'h0);
        tick();
        checkOutput({tag, "/wait0"}, oWait, 1);
        applyStimulus(1, cre, 0, 0, 1, lbN, ubN, addr, 0, 16'h0);
        tick();
        checkOutput({tag, "/wait1"}, oWait, 1);
        checkOutput({tag, "/early"}, dq, HIZ);
        tick();
        checkOutput({tag, "/wait2"}, oWait, 0);
        checkOutput({tag, "/data"}, dq, expected);
        busIdle();
        tick();
        checkOutput({tag, "/release"}, dq, HIZ);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        busIdle();
        iReset = 1'b1;
        tick();
        tick();
        iReset = 1'b0;
        checkOutput("rst/wait", oWait, 0);
        checkOutput("rst/dq", dq, HIZ);

        doRead("bcrRst", 1, 23'h080000, 0, 0, 16'h9D1F);
        doRead("rcrRst", 1, 23'h000000, 0, 0, 16'h0010);
        doRead("didr", 1, 23'h040000, 0, 0, 16'h0343);
        doRead("sel11", 1, 23'h0C0000, 0, 0, 16'h0000);

        for (int a = 0; a < 10; a++) begin
            arrayWrite(23'(a), 16'(a), 0, 0, 1);
        end
        for (int a = 0; a < 10; a++) begin
            doRead($sformatf("rd%0d", a), 0, 23'(a), 0, 0, 16'(a));
        end

        arrayWrite(23'd5, 16'h1234, 0, 0, 1);
        arrayWrite(23'd5, 16'hA5A5, 0, 1, 1);
        doRead("lane/both", 0, 23'd5, 0, 0, 16'h12A5);
        doRead("lane/noLo", 0, 23'd5, 1, 0, 16'h12FF);
        doRead("lane/noHi", 0, 23'd5, 0, 1, 16'hFFA5);

        regWrite(2'b10, 16'h8000);
        regWrite(2'b01, 16'hFFFF);
        regWrite(2'b00, 16'h1234);
        doRead("bcrWr", 1, 23'h080000, 0, 0, 16'h8000);
        doRead("didrRo", 1, 23'h040000, 0, 0, 16'h0343);
        doRead("rcrWr", 1, 23'h000000, 0, 0, 16'h1234);

        arrayWrite(23'h000400, 16'hBEEF, 0, 0, 1);
        doRead("alias", 0, 23'h000000, 0, 0, 16'hBEEF);

        arrayWrite(23'd9, 16'h0F0F, 0, 0, 0);
        doRead("wrPrio", 0, 23'd9, 0, 0, 16'h0F0F);

        applyStimulus(0, 0, 0, 1, 0, 0, 0, 23'd1, 1, 16'h1111);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 23'd2, 1, 16'h2222);
        tick();
        applyStimulus(1, 0, 0, 1, 1, 1, 1, 23'd2, 0, 16'h0);
        tick();
        busIdle();
        tick();
        doRead("b2b/first", 0, 23'd1, 0, 0, 16'h1111);
        doRead("b2b/second", 0, 23'd2, 0, 0, 16'h2222);

        applyStimulus(0, 0, 0, 1, 1, 0, 0, 23'd4, 0, 16'h0);
        tick();
        checkOutput("noop/wait0", oWait, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 23'd4, 0, 16'h0);
        tick();
        tick();
        checkOutput("noop/wait", oWait, 0);
        checkOutput("noop/dq", dq, HIZ);
        busIdle();
        tick();

        applyStimulus(0, 0, 0, 0, 1, 0, 0, 23'd3, 0, 16'h0);
        tick();
        checkOutput("rstRd/wait0", oWait, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 23'd3, 0, 16'h0);
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        checkOutput("rstRd/wait", oWait, 0);
        checkOutput("rstRd/dq", dq, HIZ);
        tick();
        checkOutput("rstRd/waitLater", oWait, 0);
        checkOutput("rstRd/dqLater", dq, HIZ);
        busIdle();
        tick();
        doRead("rstRd/bcr", 1, 23'h080000, 0, 0, 16'h9D1F);
        doRead("rstRd/data", 0, 23'd3, 0, 0, 16'h0003);

        applyStimulus(0, 0, 0, 1, 0, 0, 0, 23'd3, 1, 16'hDEAD);
        tick();
        applyStimulus(1, 0, 0, 1, 1, 1, 1, 23'd3, 0, 16'h0);
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        busIdle();
        tick();
        doRead("rstWr/data", 0, 23'd3, 0, 0, 16'h0003);

        applyStimulus(0, 0, 0, 1, 0, 0, 0, 23'd8, 1, 16'hCAFE);
        tick();
        applyStimulus(1, 0, 1, 1, 0, 1, 1, 23'd8, 0, 16'h0);
        tick();
        checkOutput("ceAbort/wait", oWait, 0);
        checkOutput("ceAbort/dq", dq, HIZ);
        busIdle();
        tick();
        doRead("ceAbort/data", 0, 23'd8, 0, 0, 16'hCAFE);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cell_ram_responder.md
CELL_RAM_RESPONDER -- requirements
Module: cell_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the emulated array depth in 16-bit words.
REQ-002 SHALL have parameter READ_LAT, default 2, iClock cycles from access start to read data driven (min 1).
REQ-003 SHALL have parameters BCR_RST, RCR_RST and DIDR_VAL, defaults 16'h9D1F, 16'h0010 and 16'h0343, the control-register reset and ID values.
REQ-004 iClock  in  1  the only clock; all logic on its rising edge.
REQ-005 iReset  in  1  synchronous, active-high reset.
REQ-006 iADV_n, iCRE, iCE_n, iOE_n, iWE_n, iLB_n, iUB_n  in  1 each  memory-bus strobes from the controller.
REQ-007 iAddr  in  23  word address; bits [19:18] select the register when iCRE=1.
REQ-008 dq  inout  16  data bus; high-Z whenever not driving.
REQ-009 oWait  out  1  high while a read is pending, low otherwise.

Function
REQ-010 SHALL sample all inputs at posedge iClock; an access start is a sample with iCE_n=0 and iADV_n=0, and SHALL latch iAddr, iCRE, iWE_n and iOE_n.
REQ-011 SHALL implement states IDLE, RD_WAIT, RD_DRIVE, WR and CR_RD; IDLE->{WR, RD_WAIT, CR_RD} on start per REQ-012..015.
REQ-012 Array write (start with CRE=0, WE_n=0) -> WR; each cycle in WR SHALL capture dq, iLB_n and iUB_n; on the first sample with iWE_n=1 or iCE_n=1 it SHALL commit the last captured word, lane [7:0] only if its captured iLB_n=0 and lane [15:8] only if its captured iUB_n=0, then return to IDLE.
REQ-013 Array read (CRE=0, WE_n=1, OE_n=0) -> RD_WAIT for READ_LAT cycles with oWait=1, then RD_DRIVE with oWait=0, driving the word while iOE_n=0 and iCE_n=0; lane [7:0] is driven only if iLB_n=0 and lane [15:8] only if iUB_n=0, and an undriven lane is high-Z.
REQ-014 Register write (CRE=1, WE_n=0): on the start cycle it SHALL load iAddr[15:0] into RCR when sel=00 or into BCR when sel=10; sel=01 (DIDR) and sel=11 are ignored; it SHALL then return to IDLE.
REQ-015 Register read (CRE=1, WE_n=1, OE_n=0) -> CR_RD with the same timing as REQ-013, returning RCR for sel=00, DIDR_VAL for 01, BCR for 10 and 16'h0000 for 11.
REQ-016 Sampled iCE_n=1 in any state SHALL force IDLE, with dq high-Z and oWait=0 from that edge.
REQ-017 A new start (iADV_n=0, iCE_n=0) in any non-IDLE state SHALL abort the current access, except that a WR in progress commits first, and SHALL begin the new access.
REQ-018 At a start with WE_n=0 and OE_n=0, the write SHALL take priority and OE SHALL be ignored.
REQ-019 Address bits above DEPTH_LOG2-1 SHALL be ignored (aliasing wrap-around).
REQ-020 A start with WE_n=1 and OE_n=1 SHALL remain in IDLE and drive nothing.

Reset
REQ-021 On reset: state=IDLE, oWait=0, dq high-Z, BCR=BCR_RST, RCR=RCR_RST, capture registers cleared.
REQ-022 A reset mid-operation SHALL abandon the access without a commit; array contents SHALL be preserved.

Structure
REQ-023 Package cell_ram_pkg SHALL hold the state enum, the register-select codes (RCR=2'b00, DIDR=2'b01, BCR=2'b10) and the default register values.
REQ-024 Sub-module cell_ram_array SHALL be a single-port synchronous 2^DEPTH_LOG2 x 16 RAM with two byte-write enables; the responder SHALL contain the FSM, the registers and the tri-state control.

Verification
REQ-025 After reset, reg-read with sel=10, 00 and 01 -> dq reads 9D1F, 0010 and 0343 READ_LAT cycles after start.
REQ-026 Write addr 0..9 with data=addr, both lanes enabled, then read 0..9 -> each returns its address, oWait high for exactly 2 cycles per read.
REQ-027 Write 16'hA5A5 to addr 5 with iUB_n=1, after pre-writing 16'h1234 -> read returns 16'h12A5; a read with iLB_n=1 leaves dq[7:0] high-Z.
REQ-028 Reg-write sel=10 with value 16'h8000, then sel=01 with 16'hFFFF -> BCR reads 8000 and DIDR still reads 0343.
REQ-029 Write 16'hBEEF at addr 23'h000400 -> read of addr 0 returns BEEF (alias at DEPTH_LOG2=10).
REQ-030 Reset asserted mid-RD_WAIT, and iCE_n raised mid-WR before WE_n rises -> dq high-Z and oWait=0 next cycle in both cases; reset leaves target data unchanged; the CE-abort commits its captured word.
